// File: rtl/ser_pkg.sv
// Shared constants, state encodings and helpers for mux_serializer.
// SER_PARITY_EN adds the PARITY state encoding.
package ser_pkg;

   localparam int WORD_W = 8;
   localparam int SEL_W  = $clog2(WORD_W);
   localparam int CNT_W  = 8;

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WORD_W - 1);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } ser_state_t;
`endif

   // Bit-period down-counter reload value: terminal count is zero.
   function automatic logic [CNT_W-1:0] period_load(input int div);
      return CNT_W'(div - 1);
   endfunction

endpackage

// File: rtl/mux8to1.sv
// Plain 8-to-1 bit multiplexer used to pick the current serial bit.
module mux8to1 (
   input  logic [7:0] in,
   input  logic [2:0] sel,
   output logic       out
);

   assign out = in[sel];

endmodule

// File: rtl/mux_serializer.sv
// LSB-first 8-bit serializer, each bit held DIV cycles, with valid/ready input.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a word; in_ready=1, outputs quiet, done pulses here
// SHIFT  | driving hold[sel] for DIV cycles per bit, sel 0..7
// PARITY | driving XOR of hold for DIV cycles, sel held at 7
module mux_serializer
   import ser_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [SEL_W-1:0]  sel,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              done
);

   localparam logic [CNT_W-1:0] CNT_LOAD = period_load(DIV);

   ser_state_t        r_state, w_state_nxt;
   logic [WORD_W-1:0] r_hold,  w_hold_nxt;
   logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
   logic [SEL_W-1:0]  r_sel,   w_sel_nxt;
   logic              r_done,  w_done_nxt;

   logic w_accept;
   logic w_tc;
   logic w_mux_bit;

   // Gated by rst so upstream never sees a handshake during reset.
   assign in_ready = (r_state == IDLE) && !rst;
   assign w_accept = in_valid && in_ready;
   assign w_tc     = (r_cnt == '0);

   mux8to1 u_mux (
      .in  (r_hold),
      .sel (r_sel),
      .out (w_mux_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= w_sel_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            w_sel_nxt = '0;
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_hold_nxt  = in_data;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         SHIFT: begin
            if (!w_tc) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (r_sel != SEL_LAST) begin
               w_sel_nxt = r_sel + 1'b1;
               w_cnt_nxt = CNT_LOAD;
            end else begin
`ifdef SER_PARITY_EN
               w_state_nxt = PARITY;
               w_cnt_nxt   = CNT_LOAD;
`else
               w_state_nxt = IDLE;
               w_sel_nxt   = '0;
               w_done_nxt  = 1'b1;
`endif
            end
         end
`ifdef SER_PARITY_EN
         PARITY: begin
            if (!w_tc) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt = IDLE;
               w_sel_nxt   = '0;
               w_done_nxt  = 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
         end
      endcase
   end

   // Parity is muxed after the bit mux so the data path stays untouched.
   always_comb begin
      ser_out   = 1'b0;
      ser_valid = 1'b0;
      case (r_state)
         SHIFT: begin
            ser_out   = w_mux_bit;
            ser_valid = 1'b1;
         end
`ifdef SER_PARITY_EN
         PARITY: begin
            ser_out   = ^r_hold;
            ser_valid = 1'b1;
         end
`endif
         default: begin
            ser_out   = 1'b0;
            ser_valid = 1'b0;
         end
      endcase
   end

   assign sel  = r_sel;
   assign done = r_done;

endmodule

// File: tb/tb_mux_serializer.sv
// Self-checking bench for mux_serializer: DIV=1 and DIV=3 instances, scoreboard of serial bits.
module tb_mux_serializer;

`ifdef SER_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   typedef struct packed {
      logic [2:0] sel;
      logic       b;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, use3, in_valid;
   logic [7:0] in_data;
   logic       in_valid1, in_valid3;
   logic       in_ready1, ser_out1, ser_valid1, done1;
   logic       in_ready3, ser_out3, ser_valid3, done3;
   logic [2:0] sel1, sel3;
   logic       obs_ready, obs_ser, obs_valid, obs_done;
   logic [2:0] obs_sel;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   valid_cnt = 0;

   assign in_valid1 = in_valid & ~use3;
   assign in_valid3 = in_valid & use3;
   assign obs_ready = use3 ? in_ready3  : in_ready1;
   assign obs_ser   = use3 ? ser_out3   : ser_out1;
   assign obs_valid = use3 ? ser_valid3 : ser_valid1;
   assign obs_done  = use3 ? done3      : done1;
   assign obs_sel   = use3 ? sel3       : sel1;

   mux_serializer #(.DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid1),
      .in_ready(in_ready1), .sel(sel1), .ser_out(ser_out1),
      .ser_valid(ser_valid1), .done(done1)
   );

   mux_serializer #(.DIV(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid3),
      .in_ready(in_ready3), .sel(sel3), .ser_out(ser_out3),
      .ser_valid(ser_valid3), .done(done3)
   );

   function automatic void push_word(input logic [7:0] d, input int div);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < div; k++)
            sbq.push_back('{sel: 3'(i), b: d[i]});
`ifdef SER_PARITY_EN
      for (int k = 0; k < div; k++)
         sbq.push_back('{sel: 3'd7, b: ^d});
`endif
   endfunction

   // Advance one cycle, sample after the falling edge, drain the scoreboard.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      #1;
      if (obs_valid === 1'b1) begin
         valid_cnt++;
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: ser_valid=1 sel=%0d but nothing expected", obs_sel);
         end else begin
            e = sbq.pop_front();
            if (obs_ser !== e.b) begin
               bad++;
               $display("FAIL sb_bit: sel=%0d got ser_out=%b expected %b", e.sel, obs_ser, e.b);
            end
            total++;
            if (obs_sel !== e.sel) begin
               bad++;
               $display("FAIL sb_sel: got sel=%0d expected %0d", obs_sel, e.sel);
            end
         end
      end
   endtask

   task automatic wait_done(input int budget, output int cyc, output bit seen);
      seen = 1'b0;
      cyc  = 1;
      while (!seen && cyc <= budget) begin
         if (obs_done === 1'b1) seen = 1'b1;
         else begin
            tick();
            cyc++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) tick();
      total++;
      if ({in_ready1, sel1, ser_out1, ser_valid1, done1} !== 7'b0) begin
         bad++;
         $display("FAIL reset_dut1: got ready,sel,out,valid,done=%b expected 0", {in_ready1, sel1, ser_out1, ser_valid1, done1});
      end
      total++;
      if ({in_ready3, sel3, ser_out3, ser_valid3, done3} !== 7'b0) begin
         bad++;
         $display("FAIL reset_dut3: got ready,sel,out,valid,done=%b expected 0", {in_ready3, sel3, ser_out3, ser_valid3, done3});
      end
      rst = 1'b0;
      tick();
      total++;
      if ({in_ready1, in_ready3} !== 2'b11) begin
         bad++;
         $display("FAIL reset_release_ready: got %b expected 11", {in_ready1, in_ready3});
      end
   endtask

   task automatic run_word(input string name, input logic [7:0] d, input int div,
                           input bit scramble);
      int cyc;
      bit seen;
      valid_cnt = 0;
      in_data   = d;
      in_valid  = 1'b1;
      push_word(d, div);
      tick();
      in_valid = 1'b0;
      if (scramble) in_data = 8'h00;
      total++;
      if (obs_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s_busy_ready: got in_ready=%b expected 0", name, obs_ready);
      end
      wait_done(12 * div + 4, cyc, seen);
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s_done_timeout: got no done expected done within %0d cycles", name, 12 * div + 4);
      end
      total++;
      if (cyc !== NB * div + 1) begin
         bad++;
         $display("FAIL %s_latency: got done at cycle %0d expected %0d", name, cyc, NB * div + 1);
      end
      total++;
      if ({obs_valid, obs_ser, obs_sel, obs_ready} !== 6'b000001) begin
         bad++;
         $display("FAIL %s_done_idle: got valid,out,sel,ready=%b expected 000001", name, {obs_valid, obs_ser, obs_sel, obs_ready});
      end
      total++;
      if (valid_cnt !== NB * div) begin
         bad++;
         $display("FAIL %s_valid_cnt: got %0d expected %0d", name, valid_cnt, NB * div);
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL %s_sb_left: got %0d pending expected 0", name, sbq.size());
      end
      tick();
      total++;
      if (obs_done !== 1'b0) begin
         bad++;
         $display("FAIL %s_done_width: got done=%b expected 0", name, obs_done);
      end
   endtask

   task automatic test_div1();
      use3 = 1'b0;
      run_word("div1_d5", 8'hD5, 1, 1'b0);
   endtask

   task automatic test_div3();
      use3 = 1'b1;
      run_word("div3_81", 8'h81, 3, 1'b0);
      use3 = 1'b0;
   endtask

   task automatic test_hold_data();
      use3 = 1'b0;
      run_word("hold_6b", 8'h6B, 1, 1'b1);
      use3 = 1'b1;
      run_word("hold3_c7", 8'hC7, 3, 1'b1);
      use3 = 1'b0;
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit seen;
      use3 = 1'b0;
      in_data  = 8'hA5;
      in_valid = 1'b1;
      push_word(8'hA5, 1);
      push_word(8'h3C, 1);
      tick();
      in_data = 8'h3C;
      wait_done(20, cyc, seen);
      total++;
      if (!seen || cyc !== NB + 1) begin
         bad++;
         $display("FAIL b2b_first_done: got seen=%0d cycle %0d expected 1 at %0d", seen, cyc, NB + 1);
      end
      total++;
      if (obs_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ready_in_done: got %b expected 1", obs_ready);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if ({obs_valid, obs_sel, obs_ser} !== 5'b10000) begin
         bad++;
         $display("FAIL b2b_second_start: got valid,sel,out=%b expected 10000", {obs_valid, obs_sel, obs_ser});
      end
      wait_done(20, cyc, seen);
      total++;
      if (!seen || cyc !== NB + 1) begin
         bad++;
         $display("FAIL b2b_second_done: got seen=%0d cycle %0d expected 1 at %0d", seen, cyc, NB + 1);
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL b2b_sb_left: got %0d pending expected 0", sbq.size());
      end
   endtask

   task automatic test_reset_abort();
      int n;
      int dones;
      use3 = 1'b0;
      in_data  = 8'hFF;
      in_valid = 1'b1;
      push_word(8'hFF, 1);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (obs_sel !== 3'd4 && n < 12) begin
         tick();
         n++;
      end
      total++;
      if (obs_sel !== 3'd4) begin
         bad++;
         $display("FAIL abort_reach_sel4: got sel=%0d expected 4", obs_sel);
      end
      rst = 1'b1;
      tick();
      total++;
      if ({obs_ready, obs_sel, obs_ser, obs_valid, obs_done} !== 7'b0) begin
         bad++;
         $display("FAIL abort_outputs: got ready,sel,out,valid,done=%b expected 0", {obs_ready, obs_sel, obs_ser, obs_valid, obs_done});
      end
      sbq.delete();
      rst = 1'b0;
      tick();
      total++;
      if ({obs_ready, obs_done} !== 2'b10) begin
         bad++;
         $display("FAIL abort_release: got ready,done=%b expected 10", {obs_ready, obs_done});
      end
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (obs_done === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
      end
   endtask

   initial begin
      rst      = 1'b1;
      use3     = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      test_reset();
      test_div1();
      test_div3();
      test_hold_data();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
